// File: rtl/stage_seq_pkg.sv
// Shared definitions for the stage sequencer.
//   state_e   : sequencer FSM states
//   idx_width : stage-index width for a given stage count (never below 1)
//   get_slice : extracts field <idx> of width <w> from a packed per-stage bus
package stage_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Widest packed bus / single field the slice helper handles.
  localparam int MAX_BUS_W   = 1024;
  localparam int MAX_FIELD_W = 64;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_FIELD_W-1:0] get_slice(
    input logic [MAX_BUS_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [MAX_BUS_W-1:0]   shifted;
    logic [MAX_FIELD_W-1:0] mask;
    shifted = bus >> (idx * w);
    // Shifting an all-ones word left by w leaves ones above the field; a
    // full-width field shifts to zero and the mask becomes all ones.
    mask = ~({MAX_FIELD_W{1'b1}} << w);
    return shifted[MAX_FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/write_port_mux.sv
// Routes the selected stage's write port onto the shared memory port.
//   idx         : selected stage
//   enable      : high while a stage is running; otherwise outputs are 0
//   stage_we    : per-stage write enables
//   stage_addr  : packed per-stage addresses, stage i at [i*ADDR_W +: ADDR_W]
//   stage_wdata : packed per-stage write data, same layout
//   mem_we/mem_addr/mem_wdata : shared port (combinational)
module write_port_mux
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8
) (
  input  logic [idx_width(NUM_STAGES)-1:0] idx,
  input  logic                             enable,
  input  logic [NUM_STAGES-1:0]            stage_we,
  input  logic [NUM_STAGES*ADDR_W-1:0]     stage_addr,
  input  logic [NUM_STAGES*DATA_W-1:0]     stage_wdata,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata
);

  logic [MAX_BUS_W-1:0] we_bus;
  logic [MAX_BUS_W-1:0] addr_bus;
  logic [MAX_BUS_W-1:0] wdata_bus;

  assign we_bus    = MAX_BUS_W'(stage_we);
  assign addr_bus  = MAX_BUS_W'(stage_addr);
  assign wdata_bus = MAX_BUS_W'(stage_wdata);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (enable) begin
      mem_we    = 1'(get_slice(we_bus, 32'(idx), 1));
      mem_addr  = ADDR_W'(get_slice(addr_bus, 32'(idx), ADDR_W));
      mem_wdata = DATA_W'(get_slice(wdata_bus, 32'(idx), DATA_W));
    end
  end

endmodule

// File: rtl/stage_sequencer_mux.sv
// Sequences NUM_STAGES sub-FSMs in order and shares one memory write port.
//   start/abort           : sequence control (start is level sampled)
//   finish/aborted        : one-cycle completion / cancellation pulses
//   busy, active_stage    : status (registered)
//   error                 : sticky stray-finish flag, cleared by an accepted start
//   stage_start/finish    : per-stage one-hot start pulse / done pulses
//   stage_we/addr/wdata   : per-stage write ports (packed)
//   mem_we/addr/wdata     : shared write port, active stage only
module stage_sequencer_mux
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int REPEAT     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  output logic                          finish,
  output logic                          aborted,
  output logic                          busy,
  output logic [$clog2(NUM_STAGES)-1:0] active_stage,
  output logic                          error,
  output logic [NUM_STAGES-1:0]         stage_start,
  input  logic [NUM_STAGES-1:0]         stage_finish,
  input  logic [NUM_STAGES-1:0]         stage_we,
  input  logic [NUM_STAGES*ADDR_W-1:0]  stage_addr,
  input  logic [NUM_STAGES*DATA_W-1:0]  stage_wdata,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata
);

  localparam int               IDX_W    = idx_width(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    error_q, error_d;
  logic                    finish_q, finish_d;
  logic                    aborted_q, aborted_d;
  logic                    busy_q, busy_d;
  logic [NUM_STAGES-1:0]   start_q, start_d;
  logic [NUM_STAGES-1:0]   idx_onehot;
  logic                    fin_cur;
  logic                    stray;
  logic                    running;

  assign running    = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign idx_onehot = NUM_STAGES'(1) << idx_q;
  assign fin_cur    = |(stage_finish & idx_onehot);
  // While running, only the current stage may finish; otherwise any finish is stray.
  assign stray      = running ? |(stage_finish & ~idx_onehot) : |stage_finish;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    error_d   = error_q;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LAUNCH;
          idx_d   = '0;
          error_d = 1'b0;
        end
      end
      ST_LAUNCH: begin
        // The current stage's finish is not looked at in the launch cycle.
        if (abort) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          aborted_d = 1'b1;
        end else if (fin_cur) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LAUNCH;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        if ((REPEAT != 0) && start) begin
          state_d = ST_LAUNCH;
          error_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
        idx_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    if (stray) error_d = 1'b1;
    // Outputs are registered from the next state so they line up with it.
    start_d  = (state_d == ST_LAUNCH) ? (NUM_STAGES'(1) << idx_d) : '0;
    finish_d = (state_d == ST_DONE);
    busy_d   = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      error_q   <= 1'b0;
      finish_q  <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      error_q   <= error_d;
      finish_q  <= finish_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
    end
  end

  assign finish       = finish_q;
  assign aborted      = aborted_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign stage_start  = start_q;
  assign active_stage = idx_q;

  write_port_mux #(
    .NUM_STAGES(NUM_STAGES),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) u_mux (
    .idx        (idx_q),
    .enable     (running),
    .stage_we   (stage_we),
    .stage_addr (stage_addr),
    .stage_wdata(stage_wdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

endmodule

// File: tb/tb_stage_sequencer_mux.sv
module tb_stage_sequencer_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  stage_finish = '0;
  logic [2:0]  stage_we = '0;
  logic [23:0] stage_addr = '0;
  logic [23:0] stage_wdata = '0;

  logic        finish, aborted, busy, error, mem_we;
  logic [1:0]  active_stage;
  logic [2:0]  stage_start;
  logic [7:0]  mem_addr, mem_wdata;

  logic        r_finish, r_aborted, r_busy, r_error, r_mem_we;
  logic [1:0]  r_active_stage;
  logic [2:0]  r_stage_start;
  logic [7:0]  r_mem_addr, r_mem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage_sequencer_mux #(.NUM_STAGES(3), .ADDR_W(8), .DATA_W(8), .REPEAT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .finish(finish), .aborted(aborted), .busy(busy), .active_stage(active_stage),
    .error(error), .stage_start(stage_start), .stage_finish(stage_finish),
    .stage_we(stage_we), .stage_addr(stage_addr), .stage_wdata(stage_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  stage_sequencer_mux #(.NUM_STAGES(3), .ADDR_W(8), .DATA_W(8), .REPEAT(1)) dut_rpt (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .finish(r_finish), .aborted(r_aborted), .busy(r_busy), .active_stage(r_active_stage),
    .error(r_error), .stage_start(r_stage_start), .stage_finish(stage_finish),
    .stage_we(stage_we), .stage_addr(stage_addr), .stage_wdata(stage_wdata),
    .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stage_we = 3'b111; stage_addr = 24'h030201; stage_wdata = 24'hFFFFFF;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %0b want 0", finish); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %0b want 0", aborted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (stage_start !== 3'b000) begin errors++; $display("FAIL reset_stage_start: got %b want 000", stage_start); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", error); end
    checks++; if (active_stage !== 2'd0) begin errors++; $display("FAIL reset_active: got %0d want 0", active_stage); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
    stage_we = '0; stage_addr = '0; stage_wdata = '0;
    $display("test_reset complete");
  endtask

  // Start held over edges 0..4; stage finishes sampled at edges 4, 7, 10.
  task automatic test_full_run();
    logic [2:0] exp_ss;
    logic       exp_fin, exp_busy;
    logic [1:0] exp_act;
    for (int e = 0; e <= 12; e++) begin
      start = (e <= 4);
      stage_finish = (e == 4) ? 3'b001 : (e == 7) ? 3'b010 : (e == 10) ? 3'b100 : 3'b000;
      tick();
      exp_ss   = (e == 0) ? 3'b001 : (e == 4) ? 3'b010 : (e == 7) ? 3'b100 : 3'b000;
      exp_fin  = (e == 10);
      exp_busy = (e <= 9);
      exp_act  = (e < 4) ? 2'd0 : (e < 7) ? 2'd1 : (e <= 10) ? 2'd2 : 2'd0;
      checks++; if (stage_start !== exp_ss) begin errors++; $display("FAIL full_stage_start e=%0d: got %b want %b", e, stage_start, exp_ss); end
      checks++; if (finish !== exp_fin) begin errors++; $display("FAIL full_finish e=%0d: got %0b want %0b", e, finish, exp_fin); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL full_busy e=%0d: got %0b want %0b", e, busy, exp_busy); end
      checks++; if (active_stage !== exp_act) begin errors++; $display("FAIL full_active e=%0d: got %0d want %0d", e, active_stage, exp_act); end
    end
    start = 1'b0; stage_finish = '0;
    $display("test_full_run complete");
  endtask

  task automatic test_mux_routing();
    start = 1'b1; tick(); start = 1'b0;
    stage_we = 3'b001; stage_addr = {8'h00, 8'h00, 8'h01}; stage_wdata = {8'h00, 8'h00, 8'hFF}; #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL mux_we_s0: got %0b want 1", mem_we); end
    checks++; if (mem_addr !== 8'h01) begin errors++; $display("FAIL mux_addr_1: got %h want 01", mem_addr); end
    checks++; if (mem_wdata !== 8'hFF) begin errors++; $display("FAIL mux_data_s0: got %h want ff", mem_wdata); end
    tick(); stage_addr = {8'h00, 8'h00, 8'h02}; #1;
    checks++; if (mem_addr !== 8'h02) begin errors++; $display("FAIL mux_addr_2: got %h want 02", mem_addr); end
    tick(); stage_addr = {8'h00, 8'h00, 8'h03}; #1;
    checks++; if (mem_addr !== 8'h03) begin errors++; $display("FAIL mux_addr_3: got %h want 03", mem_addr); end
    stage_finish = 3'b001; tick(); stage_finish = 3'b000;
    stage_we = 3'b011; stage_addr = {8'h00, 8'h09, 8'h03}; stage_wdata = {8'h00, 8'hAA, 8'hFF}; #1;
    checks++; if (mem_addr !== 8'h09) begin errors++; $display("FAIL mux_addr_9: got %h want 09", mem_addr); end
    checks++; if (mem_wdata !== 8'hAA) begin errors++; $display("FAIL mux_data_s1: got %h want aa", mem_wdata); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL mux_we_s1: got %0b want 1", mem_we); end
    tick(); stage_addr = {8'h00, 8'h08, 8'h03}; #1;
    checks++; if (mem_addr !== 8'h08) begin errors++; $display("FAIL mux_addr_8: got %h want 08", mem_addr); end
    tick(); stage_addr = {8'h00, 8'h07, 8'h03}; #1;
    checks++; if (mem_addr !== 8'h07) begin errors++; $display("FAIL mux_addr_7: got %h want 07", mem_addr); end
    stage_finish = 3'b010; tick(); stage_finish = 3'b000;
    checks++; if (active_stage !== 2'd2) begin errors++; $display("FAIL mux_active_s2: got %0d want 2", active_stage); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mux_we_s2_inactive: got %0b want 0", mem_we); end
    tick(); stage_finish = 3'b100; tick(); stage_finish = 3'b000;
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL mux_finish: got %0b want 1", finish); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL mux_addr_done: got %h want 00", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mux_we_done: got %0b want 0", mem_we); end
    tick();
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL mux_data_idle: got %h want 00", mem_wdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mux_we_idle: got %0b want 0", mem_we); end
    stage_we = '0; stage_addr = '0; stage_wdata = '0;
    $display("test_mux_routing complete");
  endtask

  task automatic test_abort();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    stage_finish = 3'b001; tick(); stage_finish = 3'b000;
    tick();
    stage_we = 3'b010; abort = 1'b1; #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL abort_we_before: got %0b want 1", mem_we); end
    tick(); abort = 1'b0;
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %0b want 1", aborted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL abort_finish: got %0b want 0", finish); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_mem_we: got %0b want 0", mem_we); end
    checks++; if (active_stage !== 2'd0) begin errors++; $display("FAIL abort_active: got %0d want 0", active_stage); end
    tick();
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort_pulse_len: got %0b want 0", aborted); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (stage_start !== 3'b001) begin errors++; $display("FAIL abort_restart: got %b want 001", stage_start); end
    abort = 1'b1; tick(); abort = 1'b0; tick();
    stage_we = '0;
    $display("test_abort complete");
  endtask

  task automatic test_stray();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    stage_finish = 3'b100; tick(); stage_finish = 3'b000;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL stray_error_set: got %0b want 1", error); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stray_busy: got %0b want 1", busy); end
    checks++; if (active_stage !== 2'd0) begin errors++; $display("FAIL stray_active: got %0d want 0", active_stage); end
    stage_finish = 3'b001; tick(); stage_finish = 3'b000;
    checks++; if (stage_start !== 3'b010) begin errors++; $display("FAIL stray_continue_s1: got %b want 010", stage_start); end
    tick(); stage_finish = 3'b010; tick(); stage_finish = 3'b000;
    tick(); stage_finish = 3'b100; tick(); stage_finish = 3'b000;
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL stray_finish: got %0b want 1", finish); end
    tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL stray_error_sticky: got %0b want 1", error); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL stray_error_clear: got %0b want 0", error); end
    abort = 1'b1; tick(); abort = 1'b0; tick();
    $display("test_stray complete");
  endtask

  task automatic test_simultaneous();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    abort = 1'b1; stage_finish = 3'b001; tick(); abort = 1'b0; stage_finish = 3'b000;
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL simul_aborted: got %0b want 1", aborted); end
    checks++; if (stage_start !== 3'b000) begin errors++; $display("FAIL simul_no_start: got %b want 000", stage_start); end
    tick();
    checks++; if (stage_start !== 3'b000) begin errors++; $display("FAIL simul_no_start_late: got %b want 000", stage_start); end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (stage_start !== 3'b000) begin errors++; $display("FAIL busy_start_ignored: got %b want 000", stage_start); end
    checks++; if (active_stage !== 2'd0) begin errors++; $display("FAIL busy_start_active: got %0d want 0", active_stage); end
    stage_finish = 3'b001; tick(); stage_finish = 3'b000;
    checks++; if (stage_start !== 3'b010) begin errors++; $display("FAIL busy_start_next: got %b want 010", stage_start); end
    abort = 1'b1; tick(); abort = 1'b0; tick();
    $display("test_simultaneous complete");
  endtask

  task automatic test_repeat();
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick();
    checks++; if (r_stage_start !== 3'b001) begin errors++; $display("FAIL rpt_first_start: got %b want 001", r_stage_start); end
    tick();
    stage_finish = 3'b001; tick(); stage_finish = 3'b000;
    tick();
    stage_finish = 3'b010; tick(); stage_finish = 3'b000;
    tick();
    stage_finish = 3'b100; tick(); stage_finish = 3'b000;
    checks++; if (r_finish !== 1'b1) begin errors++; $display("FAIL rpt_finish: got %0b want 1", r_finish); end
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL norpt_finish: got %0b want 1", finish); end
    tick();
    checks++; if (r_stage_start !== 3'b001) begin errors++; $display("FAIL rpt_relaunch: got %b want 001", r_stage_start); end
    checks++; if (r_busy !== 1'b1) begin errors++; $display("FAIL rpt_busy: got %0b want 1", r_busy); end
    checks++; if (stage_start !== 3'b000) begin errors++; $display("FAIL norpt_idle_gap: got %b want 000", stage_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL norpt_idle_busy: got %0b want 0", busy); end
    tick();
    checks++; if (stage_start !== 3'b001) begin errors++; $display("FAIL norpt_relaunch: got %b want 001", stage_start); end
    checks++; if (r_stage_start !== 3'b000) begin errors++; $display("FAIL rpt_pulse_len: got %b want 000", r_stage_start); end
    start = 1'b0; stage_we = 3'b111; #1;
    checks++; if (r_mem_we !== 1'b1) begin errors++; $display("FAIL rpt_we_wait: got %0b want 1", r_mem_we); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (r_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b want 0", r_busy); end
    checks++; if (r_stage_start !== 3'b000) begin errors++; $display("FAIL midreset_start: got %b want 000", r_stage_start); end
    checks++; if (r_finish !== 1'b0) begin errors++; $display("FAIL midreset_finish: got %0b want 0", r_finish); end
    checks++; if (r_aborted !== 1'b0) begin errors++; $display("FAIL midreset_aborted: got %0b want 0", r_aborted); end
    checks++; if (r_mem_we !== 1'b0) begin errors++; $display("FAIL midreset_mem_we: got %0b want 0", r_mem_we); end
    checks++; if (r_active_stage !== 2'd0) begin errors++; $display("FAIL midreset_active: got %0d want 0", r_active_stage); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_norpt_busy: got %0b want 0", busy); end
    stage_we = '0;
    $display("test_repeat complete");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_mux_routing();
    test_abort();
    test_stray();
    test_simultaneous();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
